// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding, frame geometry, baud increment.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int          UART_DATA_BITS       = 8;
  localparam int          UART_OVERSAMPLE      = 16;
  localparam logic [15:0] UART_TICK_INC_115200 = 16'd2416;

  // Even parity check: 1 means the data bits plus parity bit have odd weight.
  function automatic logic uart_parity_bad(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial input, valid/ready byte output, error pulses, FSM state.
// Optional parity_err signal is present when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  import uart_pkg::*;

  // Handshake: a byte transfers on every rising edge where valid && ready; data
  // is stable while valid is high and valid never drops without ready.
  logic           rx;
  logic           ready;
  logic [7:0]     data;
  logic           valid;
  logic           frame_err;
  logic           overrun;
  uart_rx_state_t state;
`ifdef UART_RX_PARITY_EN
  logic           parity_err;

  modport master (input rx, ready, output data, valid, frame_err, overrun, state, parity_err);
  modport slave  (output rx, ready, input data, valid, frame_err, overrun, state, parity_err);
`else
  modport master (input rx, ready, output data, valid, frame_err, overrun, state);
  modport slave  (output rx, ready, input data, valid, frame_err, overrun, state);
`endif

endinterface

// File: rtl/uart_tick_gen.sv
// 16-bit phase accumulator; tick_o is the registered carry out, one cycle wide.
module uart_tick_gen #(
  parameter logic [15:0] INC = 16'd2416
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  logic [15:0] acc_q;
  logic        tick_q;
  logic [16:0] sum;

  assign sum    = {1'b0, acc_q} + {1'b0, INC};
  assign tick_o = tick_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= 16'd0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= sum[15:0];
      tick_q <= sum[16];
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling 8N1 UART receiver with single-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [15:0] TICK_INC = UART_TICK_INC_115200
) (
  input  logic      clock50,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam logic [3:0] OS_MID  = 4'(UART_OVERSAMPLE / 2 - 1);
  localparam logic [3:0] OS_LAST = 4'(UART_OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic           tick;
  logic           rx_meta_q;
  logic           rxs_q;
  logic           rxs_prev_q;
  uart_rx_state_t state_q;
  logic [3:0]     os_cnt_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           frame_err_q;
  logic           overrun_q;
`ifdef UART_RX_PARITY_EN
  logic           par_q;
  logic           parity_err_q;
`endif

  logic sample_pt;
  logic byte_done;
  logic can_load;

  uart_tick_gen #(.INC(TICK_INC)) u_tick (
    .clk_i  (clock50),
    .rst_i  (reset),
    .tick_o (tick)
  );

  assign sample_pt = tick && (os_cnt_q == OS_LAST);
  assign byte_done = (state_q == STOP) && sample_pt && rxs_q;
  // A full holding register can still take the new byte if it empties this cycle.
  assign can_load  = !valid_q || bus.ready;

  always_ff @(posedge clock50) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= IDLE;
      os_cnt_q     <= 4'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= bus.rx;
      rxs_q       <= rx_meta_q;
      rxs_prev_q  <= rxs_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      if (byte_done) begin
        if (can_load) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        parity_err_q <= uart_parity_bad(shift_q, par_q);
`endif
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end

      if (tick) begin
        os_cnt_q <= os_cnt_q + 4'd1;
      end

      case (state_q)
        IDLE: begin
          if (rxs_prev_q && !rxs_q) begin
            os_cnt_q <= 4'd0;
            state_q  <= START;
          end
        end
        START: begin
          if (tick && (os_cnt_q == OS_MID)) begin
            if (!rxs_q) begin
              os_cnt_q  <= 4'd0;
              bit_cnt_q <= 3'd0;
              state_q   <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample_pt) begin
            shift_q   <= {rxs_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_pt) begin
            par_q   <= rxs_q;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (sample_pt) begin
            if (rxs_q) begin
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end
        end
        // Held-low line: stay here so the low level is not taken as a new start.
        BREAK: begin
          if (rxs_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.state     = state_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 115200 baud on a 50 MHz clock.
// Parity scenarios are compiled when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT = 434;  // clock50 cycles per bit at 115200 baud

  logic clock50 = 1'b0;
  logic reset;

  uart_rx_if bus ();

  uart_rx #(.TICK_INC(UART_TICK_INC_115200)) dut (
    .clock50 (clock50),
    .reset   (reset),
    .bus     (bus)
  );

  always #10 clock50 = ~clock50;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int last_rise_cyc = 0;
  int valid_hi_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clock50) cyc++;

  // Monitor: samples on the falling edge, between driver updates and DUT edges.
  always @(negedge clock50) begin
    if (bus.valid && !valid_prev) last_rise_cyc = cyc;
    valid_prev = bus.valid;
    if (bus.valid) valid_hi_cnt++;
    if (bus.valid && bus.ready) got_q.push_back(bus.data);
    if (bus.frame_err) fe_cnt++;
    if (bus.overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_err) pe_cnt++;
`endif
  end

  task automatic step();
    @(posedge clock50);
    #2;
  endtask

  task automatic hold_bits(input int n);
    repeat (n * BIT) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit with_par, input logic par);
    bus.rx = 1'b0;
    last_start_cyc = cyc;
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      hold_bits(1);
    end
    if (with_par) begin
      bus.rx = par;
      hold_bits(1);
    end
    bus.rx = stop;
    hold_bits(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.ready = 1'b1;
    repeat (5) step();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.data); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE); end
    reset = 1'b0;
    hold_bits(1);
  endtask

  task automatic test_low_at_reset();
    int fe0;
    int n0;
    reset = 1'b1;
    bus.rx = 1'b0;
    repeat (5) step();
    fe0 = fe_cnt;
    n0 = got_q.size();
    reset = 1'b0;
    hold_bits(11);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL lowrst_frame_err: got %0d pulses expected 1", fe_cnt - fe0); end
    checks++; if (got_q.size() != n0) begin errors++; $display("FAIL lowrst_no_valid: got %0d bytes expected %0d", got_q.size(), n0); end
    checks++; if (bus.state !== BREAK) begin errors++; $display("FAIL lowrst_break: got %0d expected %0d", bus.state, BREAK); end
    bus.rx = 1'b1;
    hold_bits(2);
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL lowrst_idle: got %0d expected %0d", bus.state, IDLE); end
  endtask

  task automatic test_single();
    int fe0, ov0, vh0, lat;
    logic [7:0] g, e;
    got_q.delete(); exp_q.delete();
    bus.ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; vh0 = valid_hi_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    hold_bits(1);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d bytes expected 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL single_data: got %h expected %h", g, e); end
    end
    lat = last_rise_cyc - last_start_cyc;
    checks++; if (lat < 4090 || lat > 4145) begin errors++; $display("FAIL single_latency: got %0d cycles expected 4090..4145", lat); end
    checks++; if (valid_hi_cnt - vh0 != 1) begin errors++; $display("FAIL single_valid_width: got %0d expected 1", valid_hi_cnt - vh0); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", fe_cnt - fe0); end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL single_overrun: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_glitch();
    int fe0, vh0;
    fe0 = fe_cnt; vh0 = valid_hi_cnt;
    bus.rx = 1'b0;
    repeat (100) step();
    bus.rx = 1'b1;
    repeat (700) step();
    checks++; if (valid_hi_cnt != vh0) begin errors++; $display("FAIL glitch_valid: got %0d valid cycles expected 0", valid_hi_cnt - vh0); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - fe0); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", bus.state, IDLE); end
  endtask

  task automatic test_frame_err();
    int fe0;
    logic [7:0] g, e;
    got_q.delete(); exp_q.delete();
    bus.ready = 1'b1;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    hold_bits(3);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d pulses expected 1", fe_cnt - fe0); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ferr_no_valid: got %0d bytes expected 0", got_q.size()); end
    bus.rx = 1'b1;
    hold_bits(1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    hold_bits(1);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL ferr_next_count: got %0d bytes expected 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL ferr_next_data: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_overrun();
    int ov0;
    logic [7:0] g;
    got_q.delete();
    bus.ready = 1'b0;
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b expected 1", bus.valid); end
    checks++; if (bus.data !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got %h expected 11", bus.data); end
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulses expected 1", ov_cnt - ov0); end
    checks++; if (bus.data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept: got %h expected 11", bus.data); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_kept: got %b expected 1", bus.valid); end
    bus.ready = 1'b1;
    step();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_fall: got %b expected 0", bus.valid); end
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL ovr_accept_count: got %0d bytes expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 8'h11) begin errors++; $display("FAIL ovr_accept_data: got %h expected 11", g); end
    end
    hold_bits(1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [7:0] g, e;
    got_q.delete(); exp_q.delete();
    bus.ready = 1'b1;
    b = 8'h5A;
    bus.rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 4; i++) begin
      bus.rx = b[i];
      hold_bits(1);
    end
    bus.rx = b[4];
    repeat (BIT / 2) step();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", bus.data); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b expected 0", bus.frame_err); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b expected 0", bus.overrun); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", bus.state, IDLE); end
    reset = 1'b0;
    bus.rx = 1'b1;
    hold_bits(1);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    hold_bits(1);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL midrst_next_count: got %0d bytes expected 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL midrst_next_data: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int ov0;
    logic [7:0] g, e;
    got_q.delete(); exp_q.delete();
    bus.ready = 1'b1;
    ov0 = ov_cnt;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hC3);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    hold_bits(1);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d bytes expected 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_data: got %h expected %h", g, e); end
    end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", ov_cnt - ov0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    logic [7:0] g;
    got_q.delete();
    bus.ready = 1'b1;
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    hold_bits(1);
    checks++; if (pe_cnt != pe0) begin errors++; $display("FAIL par_good_err: got %0d pulses expected 0", pe_cnt - pe0); end
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL par_good_count: got %0d bytes expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 8'h07) begin errors++; $display("FAIL par_good_data: got %h expected 07", g); end
    end
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    hold_bits(1);
    checks++; if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL par_bad_err: got %0d pulses expected 1", pe_cnt - pe0); end
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL par_bad_count: got %0d bytes expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %h expected 07", g); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.ready = 1'b1;
    test_reset();
    test_low_at_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
